conv_window_gen: RTL

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

---
 rtl/conv_window_gen_pkg.sv | 12 +
 rtl/conv_line_buf.sv | 26 ++
 rtl/conv_window_gen.sv | 132 +++++++++++++
 3 files changed

// File: rtl/conv_window_gen_pkg.sv
// Shared convolution constants: window size and the frame/filter index wrap
// point, also used by the weight buffer.
package conv_window_gen_pkg;

  localparam int         WIN_K          = 3;
  localparam logic [7:0] FRAME_CNT_WRAP = 8'd7;

  function automatic logic [7:0] frame_cnt_next(input logic [7:0] cnt);
    return (cnt == FRAME_CNT_WRAP) ? 8'd0 : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/conv_line_buf.sv
// One image-row line buffer. The combinational read at the write address
// returns the previous row's pixel before the same edge overwrites it.
module conv_line_buf #(
  parameter int DEPTH = 28,
  parameter int W     = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Row storage; contents are never reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator over a raster pixel stream (valid windows only).
// Optional frame counter output enabled by macro CONV_WIN_FRAME_CNT_EN.
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int M     = 8,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic         clk,
  input  logic         Rst_n,
  input  logic         pix_valid,
  input  logic [M-1:0] pix_data,
  output logic [M-1:0] P00,
  output logic [M-1:0] P01,
  output logic [M-1:0] P02,
  output logic [M-1:0] P03,
  output logic [M-1:0] P04,
  output logic [M-1:0] P05,
  output logic [M-1:0] P06,
  output logic [M-1:0] P07,
  output logic [M-1:0] P08,
  output logic         win_valid,
  output logic         fmap_finish
`ifdef CONV_WIN_FRAME_CNT_EN
  ,
  output logic [7:0]   frame_count
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int NT = WIN_K * WIN_K;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [WIN_K-1:0][M-1:0] cola_q, cola_d, colb_q, colb_d, newcol_s;
  logic [NT-1:0][M-1:0]    p_q, p_d;
  logic win_valid_q, win_valid_d, fmap_finish_q, fmap_finish_d;
  logic col_last_s, row_last_s, win_fire_s;
  logic [M-1:0] lb0_rd_s, lb1_rd_s;

  // lb1 holds row r-1; lb0 is fed from lb1 so it holds row r-2.
  conv_line_buf #(.DEPTH(IMG_W), .W(M)) u_lb0 (
    .clk(clk), .we_i(pix_valid), .addr_i(col_q), .wdata_i(lb1_rd_s), .rdata_o(lb0_rd_s)
  );
  conv_line_buf #(.DEPTH(IMG_W), .W(M)) u_lb1 (
    .clk(clk), .we_i(pix_valid), .addr_i(col_q), .wdata_i(pix_data), .rdata_o(lb1_rd_s)
  );

  assign col_last_s = (col_q == CW'(IMG_W - 1));
  assign row_last_s = (row_q == RW'(IMG_H - 1));
  assign win_fire_s = pix_valid && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign newcol_s   = {pix_data, lb1_rd_s, lb0_rd_s};

  // Next-state: raster position, column history and output window.
  always_comb begin
    col_d         = col_q;
    row_d         = row_q;
    cola_d        = cola_q;
    colb_d        = colb_q;
    p_d           = p_q;
    win_valid_d   = 1'b0;
    fmap_finish_d = 1'b0;
    if (pix_valid) begin
      cola_d = colb_q;
      colb_d = newcol_s;
      if (col_last_s) begin
        col_d = {CW{1'b0}};
        row_d = row_last_s ? {RW{1'b0}} : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      col_d = col_q;
    end
    if (win_fire_s) begin
      win_valid_d   = 1'b1;
      fmap_finish_d = col_last_s && row_last_s;
      for (int r = 0; r < WIN_K; r++) begin
        p_d[r*WIN_K + 0] = cola_q[r];
        p_d[r*WIN_K + 1] = colb_q[r];
        p_d[r*WIN_K + 2] = newcol_s[r];
      end
    end else begin
      p_d = p_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      col_q         <= {CW{1'b0}};
      row_q         <= {RW{1'b0}};
      cola_q        <= '{default: {M{1'b0}}};
      colb_q        <= '{default: {M{1'b0}}};
      p_q           <= '{default: {M{1'b0}}};
      win_valid_q   <= 1'b0;
      fmap_finish_q <= 1'b0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      cola_q        <= cola_d;
      colb_q        <= colb_d;
      p_q           <= p_d;
      win_valid_q   <= win_valid_d;
      fmap_finish_q <= fmap_finish_d;
    end
  end

`ifdef CONV_WIN_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  // Frame index advances on the same edge that raises fmap_finish.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      frame_cnt_q <= 8'd0;
    end else if (fmap_finish_d) begin
      frame_cnt_q <= frame_cnt_next(frame_cnt_q);
    end else begin
      frame_cnt_q <= frame_cnt_q;
    end
  end

  assign frame_count = frame_cnt_q;
`endif

  assign {P08, P07, P06, P05, P04, P03, P02, P01, P00} = p_q;
  assign win_valid   = win_valid_q;
  assign fmap_finish = fmap_finish_q;

endmodule
